// File: rtl/lc3_mem_access_if.sv
// ----------------------------------------------------------------------------
// lc3_mem_access_if
//
// Purpose:
//   Single-port memory bus between the LC-3 memory access sequencer and a
//   memory. The requester drives a request strobe, a write strobe, the address
//   and the write data. The memory answers with read data and a ready flag
//   that completes the current request in the same cycle.
//
// Signals:
//   mem_en     requester -> memory  request is active this cycle
//   mem_we     requester -> memory  write strobe, only high with mem_en
//   mem_addr   requester -> memory  16-bit word address
//   mem_wdata  requester -> memory  16-bit write data
//   mem_rdata  memory -> requester  16-bit read data, valid with mem_en & mem_ready
//   mem_ready  memory -> requester  current request completes this cycle
//
// Modports:
//   master  the sequencer side (lc3_mem_access)
//   slave   the memory side
// ----------------------------------------------------------------------------
interface lc3_mem_access_if;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/lc3_mem_access.sv
// ----------------------------------------------------------------------------
// lc3_mem_access
//
// Purpose:
//   Memory access sequencer for the LC-3 datapath. Takes the effective
//   address from the address adder and performs a direct load (LD/LDR),
//   direct store (ST/STR), indirect load (LDI) or indirect store (STI) over a
//   request/ready memory bus. Owns the MAR/MDR side of the datapath and
//   reports completion to the control FSM with a one-cycle done pulse.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   begin an access, only looked at while idle
//   addr[15:0]   in   effective address (or pointer location when indirect)
//   wdata[15:0]  in   store data
//   is_store     in   1 = write, 0 = read
//   is_indirect  in   1 = addr holds a pointer to the real address
//   busy         out  high in every state except IDLE
//   done         out  one-cycle completion pulse
//   err          out  timeout abort flag, valid together with done
//   rdata[15:0]  out  last loaded value, held until the next successful load
//   mem          master side of lc3_mem_access_if
//
// Parameters:
//   TIMEOUT_CYC  consecutive wait cycles tolerated before abort (1..31),
//                only meaningful when LC3_MEM_TIMEOUT_EN is defined.
//
// Build options:
//   LC3_MEM_TIMEOUT_EN  when defined, a 5-bit wait counter aborts a request
//                       that has seen TIMEOUT_CYC consecutive not-ready
//                       cycles, completing with err=1. When undefined the
//                       sequencer waits forever and err is tied low.
// ----------------------------------------------------------------------------
module lc3_mem_access #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        is_store,
    input  logic        is_indirect,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    lc3_mem_access_if.master mem
);

    // The wait counter is 5 bits wide, so the abort threshold must fit in it.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 31) begin : g_bad_timeout_cyc
        $error("lc3_mem_access: TIMEOUT_CYC must be in the range 1..31");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PTR    = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] rdata_q,     rdata_d;
    logic        is_store_q,  is_store_d;
    logic        phase_active;

`ifdef LC3_MEM_TIMEOUT_EN
    localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYC - 1);

    logic [4:0] wait_cnt_q, wait_cnt_d;
    logic       err_q,      err_d;
`endif

    // PTR and ACCESS are the two phases that hold a request on the bus.
    assign phase_active = (state_q == ST_PTR) || (state_q == ST_ACCESS);

    // Next-state and datapath update. mem_addr_q doubles as the MAR: it holds
    // the captured address during the pointer read and is overwritten with
    // the fetched pointer on the PTR->ACCESS transition, which is the only
    // point where the bus address may change while a request is active.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        is_store_d  = is_store_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mem_addr_d  = addr;
                    mem_wdata_d = wdata;
                    is_store_d  = is_store;
                    state_d     = is_indirect ? ST_PTR : ST_ACCESS;
                end
            end
            ST_PTR: begin
                if (mem.mem_ready) begin
                    mem_addr_d = mem.mem_rdata;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ready) begin
                    if (!is_store_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef LC3_MEM_TIMEOUT_EN
        // Count consecutive stalled cycles of the current phase. Reaching the
        // limit forces DONE with err raised for that one cycle; rdata is not
        // touched because the ACCESS branch above only loads on mem_ready.
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
        if (phase_active && !mem.mem_ready) begin
            if (wait_cnt_q == TIMEOUT_LAST) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 5'd1;
            end
        end
        // Any state change starts a fresh phase with a cleared counter.
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            rdata_q     <= 16'h0000;
            is_store_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            is_store_q  <= is_store_d;
        end
    end

`ifdef LC3_MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // All outputs decode straight from flops, so the bus is glitch free and
    // a synchronous reset returns every output to idle on the next cycle.
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign rdata         = rdata_q;
    assign mem.mem_en    = phase_active;
    assign mem.mem_we    = (state_q == ST_ACCESS) && is_store_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
